// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full adder walks the operands LSB-first,
// with the carry held in a flop between bits and a start/busy/done handshake.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Handshake: start is sampled on a rising edge only in IDLE or DONE; busy is high
  // for exactly WIDTH cycles after acceptance, then done pulses for one cycle while
  // sum/cout/ovf hold the result until the next completed add.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_msb_q, c_msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_sum;
  logic fa_cout;

  always_comb begin
    fa_sum  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_cout = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    c_msb_d  = c_msb_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (start) begin
          state_d  = ST_RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          c_msb_d  = 1'b0;
        end
      end
      ST_RUN: begin
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CW'(1);
        // Carry out of bit WIDTH-2 is the carry into the MSB, needed for signed overflow.
        if (cnt_q == CW'(WIDTH - 2)) c_msb_d = fa_cout;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
          sum_d   = {fa_sum, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          ovf_d   = c_msb_q ^ fa_cout;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      c_msb_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      c_msb_q  <= c_msb_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: drives adds on the falling edge, predicts {ovf,cout,sum}
// from integer arithmetic into a queue, and compares when done pulses.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  logic [W+1:0] exp_q[$];
  int n_checks;
  int n_fail;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum}; ovf when operands share a sign the sum does not.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic ci);
    logic [W:0] s;
    logic       v;
    s = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
    v = (av[W-1] == bv[W-1]) && (s[W-1] != av[W-1]);
    return {v, s};
  endfunction

  // Driver tasks
  task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    exp_q.push_back(model(av, bv, ci));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [W+1:0] got;
    got = {ovf, cout, sum};
    n_checks++;
    if (got !== '0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset: ovf/cout/sum=%h busy=%b done=%b state=%0d, want 0 0 0 0",
               got, busy, done, dbg_state);
    end
  endtask

  task automatic test_arith(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                            input string name);
    int n;
    logic [W+1:0] exp;
    logic [W+1:0] got;
    do_start(av, bv, ci);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: busy=%b done=%b, want 1 0", name, busy, done);
    end
    wait_done(n);
    n_checks++;
    if (n !== W) begin
      n_fail++;
      $display("FAIL %s latency: %0d cycles, want %0d", name, n, W);
    end
    got = {ovf, cout, sum};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: ovf/cout/sum=%h busy=%b, want %h busy=0", name, got, busy, exp);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {ovf, cout, sum} !== exp) begin
      n_fail++;
      $display("FAIL %s pulse/hold: done=%b busy=%b out=%h, want 0 0 %h",
               name, done, busy, {ovf, cout, sum}, exp);
    end
  endtask

  task automatic test_start_in_run();
    int n;
    logic [W+1:0] exp;
    do_start(8'h12, 8'h34, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        a = 8'hAA; b = 8'h55; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    n_checks++;
    if (n !== W) begin
      n_fail++;
      $display("FAIL ignore_start latency: %0d cycles, want %0d", n, W);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if ({ovf, cout, sum} !== exp || exp[W-1:0] !== 8'h46) begin
      n_fail++;
      $display("FAIL ignore_start result: got %h, want %h", {ovf, cout, sum}, exp);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start dropped: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen_done;
    do_start(8'h5A, 8'h21, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ovf, cout, sum} !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run async: out=%h busy=%b done=%b, want 0 0 0",
               {ovf, cout, sum}, busy, done);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL reset_mid_run abort: done=1 seen after reset, want none");
    end
    test_arith(8'h5A, 8'h21, 1'b1, "after_reset");
  endtask

  task automatic test_back_to_back();
    int n;
    logic [W+1:0] exp;
    do_start(8'h3C, 8'h0A, 1'b0);
    wait_done(n);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (n !== W || {ovf, cout, sum} !== exp) begin
      n_fail++;
      $display("FAIL b2b first: %0d cycles out=%h, want %0d %h", n, {ovf, cout, sum}, W, exp);
    end
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h01, 8'h01, 1'b0));
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || dbg_state !== 2'd1 || {ovf, cout, sum} !== exp) begin
      n_fail++;
      $display("FAIL b2b accept: busy=%b done=%b state=%0d out=%h, want 1 0 1 %h",
               busy, done, dbg_state, {ovf, cout, sum}, exp);
    end
    wait_done(n);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (n !== W || {ovf, cout, sum} !== exp || sum !== 8'h02) begin
      n_fail++;
      $display("FAIL b2b second: %0d cycles out=%h, want %0d %h", n, {ovf, cout, sum}, W, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;

    test_arith(8'h0F, 8'h01, 1'b0, "add_basic");
    test_arith(8'hFF, 8'h01, 1'b0, "carry_out");
    test_arith(8'hFF, 8'hFF, 1'b1, "all_ones_cin");
    test_arith(8'h7F, 8'h01, 1'b0, "ovf_pos");
    test_arith(8'h80, 8'h80, 1'b0, "ovf_neg");
    test_start_in_run();
    test_reset_mid_run();
    test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      test_arith(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), "random");
    end

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
